// File: rtl/ifu_fetch_ctrl_if.sv
// Instruction-bus request/response bundle between the fetch unit and memory.
// Only one transaction is ever outstanding on this bus.
interface ifu_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [31:0]     rdata;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// IF-stage fetch controller: owns the fetch PC and the ibus handshake.
// FETCH_MISAL_CHK_EN adds an EXC state for misaligned redirect targets.
module ifu_fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RST_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_flush,
  input  logic [XLEN-1:0]  flush_pc,
  input  logic             ex_is_mret_inst,
  input  logic [XLEN-1:0]  mepc,
  input  logic             ex_bj_flag,
  input  logic [XLEN-1:0]  ex_bj_pc,
  input  logic             if_fire,
  ifu_fetch_ctrl_if.master ibus,
  output logic [XLEN-1:0]  if_pc,
  output logic [31:0]      if_inst,
  output logic             fetch_hand_suc,
  output logic             inst_useless,
  output logic             inst_valid,
  output logic             if_exp_flag,
  output logic             if_inst_addr_misal
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, DROP, HOLD
`ifdef FETCH_MISAL_CHK_EN
    , EXC
`endif
  } state_t;

  state_t          state;
  state_t          tgt_st;
  state_t          pc_st;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] pc4;
  logic [31:0]     ibuf;
  logic            drop_pend;
  logic            redir;

  assign redir = pipe_flush | ex_is_mret_inst | ex_bj_flag;
  assign tgt   = pipe_flush      ? flush_pc :
                 ex_is_mret_inst ? mepc     : ex_bj_pc;
  assign pc4   = if_pc + XLEN'(4);

  // State entered when a fetch is (re)started at tgt or at if_pc
`ifdef FETCH_MISAL_CHK_EN
  assign tgt_st = (|tgt[1:0])   ? EXC : REQ;
  assign pc_st  = (|if_pc[1:0]) ? EXC : REQ;
`else
  assign tgt_st = REQ;
  assign pc_st  = REQ;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      if_pc     <= RST_ADDR;
      req_addr  <= RST_ADDR;
      ibuf      <= '0;
      drop_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redir) begin
            if_pc    <= tgt;
            req_addr <= tgt;
            state    <= tgt_st;
          end else begin
            state    <= REQ;
          end
        end
        REQ: begin
          if (redir) if_pc <= tgt;
          if (ibus.gnt) begin
            drop_pend <= 1'b0;
            state     <= (drop_pend | redir) ? DROP : WAIT;
          end else if (redir) begin
            drop_pend <= 1'b1;
          end
        end
        WAIT: begin
          if (ibus.rvalid) begin
            if (redir) begin
              if_pc    <= tgt;
              req_addr <= tgt;
              state    <= tgt_st;
            end else if (if_fire) begin
              if_pc    <= pc4;
              req_addr <= pc4;
              state    <= REQ;
            end else begin
              ibuf  <= ibus.rdata;
              state <= HOLD;
            end
          end else if (redir) begin
            if_pc <= tgt;
            state <= DROP;
          end
        end
        DROP: begin
          if (ibus.rvalid) begin
            if (redir) begin
              if_pc    <= tgt;
              req_addr <= tgt;
              state    <= tgt_st;
            end else begin
              req_addr <= if_pc;
              state    <= pc_st;
            end
          end else if (redir) begin
            if_pc <= tgt;
          end
        end
        HOLD: begin
          if (redir) begin
            if_pc    <= tgt;
            req_addr <= tgt;
            state    <= tgt_st;
          end else if (if_fire) begin
            if_pc    <= pc4;
            req_addr <= pc4;
            state    <= REQ;
          end
        end
`ifdef FETCH_MISAL_CHK_EN
        EXC: begin
          if (redir) begin
            if_pc    <= tgt;
            req_addr <= tgt;
            state    <= tgt_st;
          end else if (if_fire) begin
            if_pc    <= pc4;
            req_addr <= pc4;
            state    <= REQ;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign ibus.req = (state == REQ);

  always_comb begin
    if_inst = ibus.rdata;
    if (state == HOLD) if_inst = ibuf;
`ifdef FETCH_MISAL_CHK_EN
    if (state == EXC) if_inst = 32'h0000_0013;
`endif
  end

`ifdef FETCH_MISAL_CHK_EN
  assign ibus.addr          = req_addr;
  assign inst_valid         = (state == HOLD) | (state == EXC);
  assign if_exp_flag        = (state == EXC);
  assign if_inst_addr_misal = (state == EXC);
`else
  assign ibus.addr          = req_addr & ~XLEN'(3);
  assign inst_valid         = (state == HOLD);
  assign if_exp_flag        = 1'b0;
  assign if_inst_addr_misal = 1'b0;
`endif

  assign fetch_hand_suc = ibus.rvalid &
                          ((state == WAIT) | (state == DROP));
  assign inst_useless   = ibus.rvalid &
                          ((state == DROP) | ((state == WAIT) & redir));

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: directed plan steps, then random traffic,
// all checked against a transaction-level fetch model.
module tb_ifu_fetch_ctrl;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_flush = 1'b0;
  logic        ex_is_mret_inst = 1'b0;
  logic        ex_bj_flag = 1'b0;
  logic        if_fire = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] mepc = '0;
  logic [31:0] ex_bj_pc = '0;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_hand_suc;
  logic        inst_useless;
  logic        inst_valid;
  logic        if_exp_flag;
  logic        if_inst_addr_misal;

  ifu_fetch_ctrl_if #(.XLEN(32)) ibus ();

  ifu_fetch_ctrl #(.XLEN(32), .RST_ADDR(32'h0)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pipe_flush         (pipe_flush),
    .flush_pc           (flush_pc),
    .ex_is_mret_inst    (ex_is_mret_inst),
    .mepc               (mepc),
    .ex_bj_flag         (ex_bj_flag),
    .ex_bj_pc           (ex_bj_pc),
    .if_fire            (if_fire),
    .ibus               (ibus),
    .if_pc              (if_pc),
    .if_inst            (if_inst),
    .fetch_hand_suc     (fetch_hand_suc),
    .inst_useless       (inst_useless),
    .inst_valid         (inst_valid),
    .if_exp_flag        (if_exp_flag),
    .if_inst_addr_misal (if_inst_addr_misal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int fails = 0;

  // model: one fetch transaction at a time
  logic        m_idle = 1'b1;
  logic        m_req = 1'b0;
  logic        m_fly = 1'b0;
  logic        m_sq = 1'b0;
  logic        m_hold = 1'b0;
  logic        m_exc = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_word = '0;

  logic        s_pend = 1'b0;
  logic [31:0] rdata_v = '0;
  logic [31:0] addr_log[$];
  int          n_fhs = 0;
  int          n_use = 0;
  logic        l_req, l_use, l_val, l_exp;
  logic [31:0] l_addr, l_inst;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_start(input logic [31:0] a);
`ifdef FETCH_MISAL_CHK_EN
    if (a[1:0] != 2'b00) begin
      m_exc = 1'b1;
      return;
    end
`endif
    m_req  = 1'b1;
    m_addr = a;
  endtask

  function automatic logic [31:0] bus_addr(input logic [31:0] a);
`ifdef FETCH_MISAL_CHK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  task automatic step(input logic fl, input logic [31:0] fpc,
                      input logic mr, input logic [31:0] mp,
                      input logic bj, input logic [31:0] bp,
                      input logic fire, input logic gen,
                      input logic ren);
    logic        redir, beat, g, rv;
    logic [31:0] tgt, exp_inst;
    @(negedge clk);
    pipe_flush      = fl;
    flush_pc        = fpc;
    ex_is_mret_inst = mr;
    mepc            = mp;
    ex_bj_flag      = bj;
    ex_bj_pc        = bp;
    if_fire         = fire;
    ibus.gnt        = ibus.req & gen;
    ibus.rvalid     = s_pend & ren;
    ibus.rdata      = rdata_v;
    #1;
    g        = ibus.gnt;
    rv       = ibus.rvalid;
    redir    = fl | mr | bj;
    tgt      = fl ? fpc : (mr ? mp : bp);
    beat     = rv & m_fly;
    exp_inst = m_exc ? NOP : (m_hold ? m_word : rdata_v);
    chk("if_pc", if_pc, m_pc);
    chk("ibus_req", 32'(ibus.req), 32'(m_req));
    if (m_req) chk("ibus_addr", ibus.addr, bus_addr(m_addr));
    chk("inst_valid", 32'(inst_valid), 32'(m_hold | m_exc));
    chk("fetch_hand_suc", 32'(fetch_hand_suc), 32'(beat));
    chk("inst_useless", 32'(inst_useless), 32'(beat & (m_sq | redir)));
    chk("if_inst", if_inst, exp_inst);
    chk("if_exp_flag", 32'(if_exp_flag), 32'(m_exc));
    chk("if_inst_addr_misal", 32'(if_inst_addr_misal), 32'(m_exc));
    l_req  = ibus.req;
    l_addr = ibus.addr;
    l_use  = inst_useless;
    l_val  = inst_valid;
    l_exp  = if_exp_flag;
    l_inst = if_inst;
    if (g) addr_log.push_back(ibus.addr);
    n_fhs += int'(fetch_hand_suc);
    n_use += int'(inst_useless);
    @(posedge clk);
    if (rv) s_pend = 1'b0;
    if (g) s_pend = 1'b1;
    if (m_idle) begin
      m_idle = 1'b0;
      if (redir) m_pc = tgt;
      m_start(m_pc);
    end else if (m_req) begin
      if (redir) begin
        m_pc = tgt;
        m_sq = 1'b1;
      end
      if (g) begin
        m_req = 1'b0;
        m_fly = 1'b1;
      end
    end else if (m_fly) begin
      if (rv) begin
        m_fly = 1'b0;
        if (m_sq || redir) begin
          if (redir) m_pc = tgt;
          m_start(m_pc);
        end else if (fire) begin
          m_pc = m_pc + 32'd4;
          m_start(m_pc);
        end else begin
          m_hold = 1'b1;
          m_word = rdata_v;
        end
        m_sq = 1'b0;
      end else if (redir) begin
        m_pc = tgt;
        m_sq = 1'b1;
      end
    end else if (m_hold || m_exc) begin
      if (redir || fire) begin
        m_pc   = redir ? tgt : m_pc + 32'd4;
        m_hold = 1'b0;
        m_exc  = 1'b0;
        m_start(m_pc);
      end
    end
  endtask

  task automatic go(input logic fire, input logic gen, input logic ren);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0, fire, gen, ren);
  endtask

  task automatic bj(input logic [31:0] pc, input logic fire,
                    input logic gen, input logic ren);
    step(1'b0, '0, 1'b0, '0, 1'b1, pc, fire, gen, ren);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] t;
    ibus.gnt    = 1'b0;
    ibus.rvalid = 1'b0;
    ibus.rdata  = '0;

    @(negedge clk);
    #1;
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_req", 32'(ibus.req), 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_fhs", 32'(fetch_hand_suc), 32'h0);
    chk("rst_useless", 32'(inst_useless), 32'h0);
    chk("rst_exp", 32'(if_exp_flag), 32'h0);
    chk("rst_misal", 32'(if_inst_addr_misal), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    rdata_v = 32'h0050_0093;
    for (int i = 0; i < 8; i++) go(1'b1, 1'b1, 1'b1);
    chk("t1_addr0", addr_log[0], 32'h0);
    chk("t1_addr1", addr_log[1], 32'h4);
    chk("t1_addr2", addr_log[2], 32'h8);
    chk("t1_fhs_cnt", 32'(n_fhs), 32'd3);
    chk("t1_useless_cnt", 32'(n_use), 32'd0);

    w       = $urandom;
    rdata_v = w;
    go(1'b0, 1'b1, 1'b1);
    go(1'b0, 1'b1, 1'b1);
    go(1'b0, 1'b1, 1'b1);
    go(1'b0, 1'b1, 1'b1);
    chk("t2_hold_valid", 32'(l_val), 32'h1);
    chk("t2_hold_noreq", 32'(l_req), 32'h0);
    chk("t2_hold_inst", l_inst, w);
    go(1'b0, 1'b1, 1'b1);
    go(1'b0, 1'b1, 1'b1);
    rdata_v = $urandom;
    go(1'b1, 1'b1, 1'b1);
    go(1'b1, 1'b1, 1'b1);
    chk("t2_next_addr", l_addr, 32'h10);

    bj(32'h100, 1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b0);
    go(1'b1, 1'b1, 1'b1);
    chk("t3_useless", 32'(l_use), 32'h1);

    bj(32'h200, 1'b1, 1'b0, 1'b1);
    chk("t3_redir_addr", l_addr, 32'h100);
    go(1'b1, 1'b0, 1'b1);
    chk("t4_addr_held", l_addr, 32'h100);
    go(1'b1, 1'b1, 1'b1);
    go(1'b1, 1'b1, 1'b1);
    chk("t4_useless", 32'(l_use), 32'h1);
    go(1'b0, 1'b1, 1'b1);
    chk("t4_new_addr", l_addr, 32'h200);
    go(1'b0, 1'b1, 1'b1);

    step(1'b1, 32'h80, 1'b0, '0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b1);
    go(1'b0, 1'b1, 1'b1);
    chk("t5_flush_prio", l_addr, 32'h80);
    go(1'b0, 1'b1, 1'b1);

    bj(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
    go(1'b1, 1'b1, 1'b1);
    go(1'b1, 1'b1, 1'b1);
    go(1'b0, 1'b1, 1'b1);
    chk("wrap_addr", l_addr, 32'h0);
    go(1'b0, 1'b1, 1'b1);

    bj(32'h102, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0);
`ifdef FETCH_MISAL_CHK_EN
    chk("t6_noreq", 32'(l_req), 32'h0);
    chk("t6_exp", 32'(l_exp), 32'h1);
    chk("t6_nop", l_inst, NOP);
`else
    chk("t6_req", 32'(l_req), 32'h1);
    chk("t6_addr", l_addr, 32'h100);
    chk("t6_exp", 32'(l_exp), 32'h0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic fl, mr, b;
      logic [31:0] p0, p1, p2;
      fl = ($urandom_range(15) == 0);
      mr = ($urandom_range(15) == 0);
      b  = ($urandom_range(7) == 0);
      p0 = ($urandom & 32'hFFC) | (($urandom_range(7) == 0) ? 32'h2 : 32'h0);
      p1 = ($urandom & 32'hFFC) | (($urandom_range(7) == 0) ? 32'h1 : 32'h0);
      p2 = ($urandom & 32'hFFC) | (($urandom_range(7) == 0) ? 32'h3 : 32'h0);
      rdata_v = $urandom;
      step(fl, p0, mr, p1, b, p2, 1'($urandom_range(1)),
           ($urandom_range(9) < 6), ($urandom_range(9) < 6));
    end

    t = $urandom;
    bj(t & 32'hFFC, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(ibus.req), 32'h0);
    chk("midrst_if_pc", if_pc, 32'h0);
    chk("midrst_valid", 32'(inst_valid), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Instruction-fetch controller in the IF stage; drives the instruction-bus request/response handshake and owns the fetch PC. It produces `inst_valid`, `fetch_hand_suc` and `inst_useless`, which the IF/ID pipeline register uses to decide whether a fetched instruction may advance. It discards responses belonging to fetches squashed by branch, mret or flush redirects. At most one bus transaction is outstanding at any time.

## Interface
- `XLEN`, 32, datapath/address width
- `RST_ADDR`, 32'h0000_0000, first fetch address after reset
- `clk` in 1, clock
- `rst_n` in 1, asynchronous active-low reset
- `pipe_flush` in 1, trap/flush redirect; `flush_pc` in XLEN, its target
- `ex_is_mret_inst` in 1, mret redirect; `mepc` in XLEN, its target
- `ex_bj_flag` in 1, branch/jump redirect; `ex_bj_pc` in XLEN, its target
- `if_fire` in 1, IF/ID accepted the current instruction this cycle (`if_id_valid & id_allowin`)
- `ibus_req` out 1, request valid; `ibus_addr` out XLEN, request address
- `ibus_gnt` in 1, request accepted; `ibus_rvalid` in 1, response beat; `ibus_rdata` in 32, response data
- `if_pc` out XLEN, PC of the instruction being fetched or held
- `if_inst` out 32, `ibus_rdata` when not in HOLD/EXC, else held/NOP word
- `fetch_hand_suc` out 1, `ibus_rvalid` seen this cycle
- `inst_useless` out 1, this cycle's response belongs to a squashed fetch
- `inst_valid` out 1, buffered instruction valid (HOLD or EXC)
- `if_exp_flag`, `if_inst_addr_misal` out 1, fetch-address-misaligned exception

## Operation
- Redirect = `pipe_flush | ex_is_mret_inst | ex_bj_flag`. Priority: flush > mret > bj. The target is loaded into `if_pc` on the next edge.
- States: IDLE, REQ, WAIT, DROP, HOLD, and EXC (macro only).
- IDLE: entered only from reset; goes to REQ after one cycle.
- REQ: `ibus_req=1`. `ibus_addr` comes from the `req_addr` register and stays stable until `gnt`.
  - Redirect without `gnt`: update `if_pc` and set `drop_pend`.
  - `gnt` with `drop_pend` or a same-cycle redirect: go to DROP.
  - Otherwise `gnt`: go to WAIT.
- WAIT: on `rvalid`:
  - With redirect: `inst_useless=1`, go to REQ at the target.
  - With `if_fire`: `if_pc += 4`, go to REQ.
  - Otherwise: latch `ibus_rdata` into the buffer, go to HOLD.
  - Redirect without `rvalid`: go to DROP.
- DROP: `rvalid` gives `fetch_hand_suc=1` and `inst_useless=1`, then go to REQ. A further redirect only updates `if_pc`.
- HOLD: `inst_valid=1`.
  - Redirect: discard the buffer, go to REQ at the target.
  - `if_fire`: `if_pc += 4`, go to REQ.
- `req_addr` is loaded from the next `if_pc` on every entry to REQ. `drop_pend` clears on leaving REQ.
- PC arithmetic is modulo 2^XLEN; wrap at all-ones is silent.
- `pipe_stall` is not an input. Stalls show up as the absence of `if_fire`, which makes the block park in HOLD.

## Timing
- Reset values:
  - state IDLE, `if_pc=req_addr=RST_ADDR`
  - `ibus_req=0`, `inst_valid=0`, `fetch_hand_suc=0`, `inst_useless=0`, `if_exp_flag=0`, `if_inst_addr_misal=0`
  - buffer 0, `drop_pend=0`
- First `ibus_req` is asserted in cycle 2 after reset release.
- Zero-wait bus (`gnt` in REQ, `rvalid` next cycle, `if_fire` same cycle): one instruction every 2 cycles.
- `fetch_hand_suc` and `inst_useless` are combinational from `ibus_rvalid` and the current state/redirect. `inst_valid` is registered (state).
- Reset asserted mid-transaction returns to IDLE immediately; the bus owner is reset by the same `rst_n`.

## Configuration
- `FETCH_MISAL_CHK_EN` defined:
  - A redirect target with `[1:0]!=0` enters EXC instead of REQ (from REQ, WAIT or DROP the in-flight beat is still drained, then EXC).
  - EXC: no bus request; `inst_valid=1`, `if_exp_flag=if_inst_addr_misal=1`, `if_inst=32'h0000_0013`.
  - EXC is left on `if_fire` (to REQ at `if_pc+4`) or on a redirect.
- Undefined: `ibus_addr[1:0]` is forced to 0, `if_exp_flag` and `if_inst_addr_misal` are tied to 0, and the EXC state does not exist.

## Test plan
- Reset release, `gnt` immediate, `rvalid` next cycle, `rdata=32'h00500093`, `if_fire` tied 1 → addresses 0x0, 0x4, 0x8 on consecutive requests. `fetch_hand_suc` pulses every 2 cycles and `inst_useless` stays 0.
- `if_fire=0` for 5 cycles after `rvalid` → HOLD, `inst_valid=1`, `if_inst` stable at the latched word, no new `ibus_req`. First `if_fire` → next request at `if_pc+4`.
- `ex_bj_flag` with `ex_bj_pc=0x100` during WAIT, `rvalid` 3 cycles later → that beat has `inst_useless=1`, then `ibus_addr=0x100`.
- Redirect to 0x200 in REQ while `gnt` is held low 2 cycles → `ibus_addr` holds the old address until `gnt`. Its response is flagged useless, then 0x200 is requested.
- `pipe_flush` (`flush_pc=0x80`) together with `ex_bj_flag` (`ex_bj_pc=0x40`) in HOLD → next `ibus_addr=0x80`.
- With `FETCH_MISAL_CHK_EN`: `ex_bj_pc=0x102` → no `ibus_req`, `if_exp_flag=if_inst_addr_misal=1`, `if_inst=32'h00000013`. Without the macro: the request goes out at 0x100 and the exception flags stay 0.
